// File: rtl/trashbin_mem_pkg.sv
// ---------------------------------------------------------------------------
// trashbin_mem_pkg
//
// Shared definitions for the TrashbinSOC data-memory path.
//   arb_state_t      : sequencing states of memory_bus_arbiter
//   PORT_CORE/AUX    : port indices (0 = TrashbinCore bus, 1 = loader / DMA)
//   DEFAULT_ADDR_W   : TempRam word-address width
//   DEFAULT_DATA_W   : TempRam data width
// ---------------------------------------------------------------------------
package trashbin_mem_pkg;

    localparam int DEFAULT_ADDR_W = 14;
    localparam int DEFAULT_DATA_W = 32;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_AUX  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        DONE
    } arb_state_t;

endpackage : trashbin_mem_pkg

// File: rtl/rr_grant_2.sv
// ---------------------------------------------------------------------------
// rr_grant_2
//
// Two-way grant picker for memory_bus_arbiter.
//
// Configuration macro: MEMORY_BUS_ARBITER_ROUND_ROBIN_EN
//   defined   : ties go to the port that did not win last time; a LastGrant
//               register (reset to PORT_AUX) tracks the most recent winner.
//   undefined : fixed priority, port 0 wins every tie, no state is built.
//
// Ports
//   clk          in  : clock
//   reset        in  : synchronous active-high reset
//   req[1:0]     in  : request per port (bit 0 = core, bit 1 = aux)
//   update       in  : a grant is being taken this cycle
//   grant_valid  out : at least one port is requesting
//   grant_port   out : index of the winning port (valid with grant_valid)
// ---------------------------------------------------------------------------
module rr_grant_2
    import trashbin_mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic       grant_valid,
    output logic       grant_port
);

    assign grant_valid = |req;

`ifdef MEMORY_BUS_ARBITER_ROUND_ROBIN_EN

    logic last_grant;

    // Reset to PORT_AUX so the core wins the very first tie.
    // NOTE: sequential state is written with non-blocking (<=) so every flop
    // samples pre-edge values; blocking here would make results depend on
    // process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= PORT_AUX;
        end else if (update && grant_valid) begin
            last_grant <= grant_port;
        end
    end

    // NOTE: every combinational output gets a default before any branch; a
    // path that leaves it unassigned would infer a latch.
    always_comb begin
        grant_port = PORT_CORE;
        if (req == 2'b11) begin
            grant_port = ~last_grant;
        end else if (req[1]) begin
            grant_port = PORT_AUX;
        end
    end

`else

    // Fixed priority: the aux port only wins when the core is silent.
    always_comb begin
        grant_port = PORT_CORE;
        if (!req[0] && req[1]) begin
            grant_port = PORT_AUX;
        end
    end

    // No LastGrant register in this build, so clock/reset/update are spare.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, clk, reset, update};

`endif

endmodule : rr_grant_2

// File: rtl/memory_bus_arbiter.sv
// ---------------------------------------------------------------------------
// memory_bus_arbiter
//
// Shares the single-port TempRam between the TrashbinCore bus (port 0) and a
// second master such as a boot loader or DMA engine (port 1). Each access is
// sequenced IDLE -> ACCESS -> [WAIT x RAM_READ_LATENCY] -> DONE, so a write
// acks two cycles after it is sampled and a read 2 + RAM_READ_LATENCY cycles
// after.
//
// Configuration macro: MEMORY_BUS_ARBITER_ROUND_ROBIN_EN
//   defined   : round-robin tie-break; undefined : port 0 always wins ties.
//
// Parameters
//   ADDR_W            : RAM word-address width
//   DATA_W            : data width
//   RAM_READ_LATENCY  : cycles from address edge to valid RamReadData (1..3)
//
// Ports
//   CoreClock                 in  : sole clock, rising edge
//   Reset                     in  : synchronous, active-high
//   P0Req / P1Req             in  : request, held until Ack
//   P0Address / P1Address     in  : word address, stable while Req
//   P0WriteData / P1WriteData in  : write data, stable while Req
//   P0Write / P1Write         in  : 1 = write, 0 = read, stable while Req
//   P0Ack / P1Ack             out : one-cycle completion pulse
//   P0ReadData / P1ReadData   out : registered read result per port
//   RamAddress                out : TempRam address (holds last latched value)
//   RamWriteData              out : TempRam write data (holds last latched)
//   RamWrite                  out : TempRam write enable, only in ACCESS
//   RamReadData               in  : TempRam q
// ---------------------------------------------------------------------------
module memory_bus_arbiter
    import trashbin_mem_pkg::*;
#(
    parameter int ADDR_W           = DEFAULT_ADDR_W,
    parameter int DATA_W           = DEFAULT_DATA_W,
    parameter int RAM_READ_LATENCY = 1
) (
    input  logic              CoreClock,
    input  logic              Reset,

    input  logic              P0Req,
    input  logic [ADDR_W-1:0] P0Address,
    input  logic [DATA_W-1:0] P0WriteData,
    input  logic              P0Write,
    output logic              P0Ack,
    output logic [DATA_W-1:0] P0ReadData,

    input  logic              P1Req,
    input  logic [ADDR_W-1:0] P1Address,
    input  logic [DATA_W-1:0] P1WriteData,
    input  logic              P1Write,
    output logic              P1Ack,
    output logic [DATA_W-1:0] P1ReadData,

    output logic [ADDR_W-1:0] RamAddress,
    output logic [DATA_W-1:0] RamWriteData,
    output logic              RamWrite,
    input  logic [DATA_W-1:0] RamReadData
);

    // The WAIT down-counter is loaded with LATENCY-1 and leaves on zero, so
    // WAIT lasts exactly RAM_READ_LATENCY cycles. Two bits cover 1..3.
    localparam logic [1:0] WAIT_LOAD = 2'(RAM_READ_LATENCY - 1);

    arb_state_t state;
    arb_state_t next_state;

    logic [1:0] wait_cnt;
    logic       req_port;
    logic       req_write;

    logic       grant_valid;
    logic       grant_port;
    logic       grant_take;
    logic       read_done;

    logic [ADDR_W-1:0] sel_address;
    logic [DATA_W-1:0] sel_write_data;
    logic              sel_write;

    // -----------------------------------------------------------------------
    // Grant selection
    // -----------------------------------------------------------------------
    rr_grant_2 u_grant (
        .clk         (CoreClock),
        .reset       (Reset),
        .req         ({P1Req, P0Req}),
        .update      (grant_take),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    always_comb begin
        sel_address    = P0Address;
        sel_write_data = P0WriteData;
        sel_write      = P0Write;
        if (grant_port == PORT_AUX) begin
            sel_address    = P1Address;
            sel_write_data = P1WriteData;
            sel_write      = P1Write;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        next_state = state;
        grant_take = 1'b0;
        read_done  = 1'b0;
        RamWrite   = 1'b0;
        P0Ack      = 1'b0;
        P1Ack      = 1'b0;

        case (state)
            IDLE: begin
                if (grant_valid) begin
                    grant_take = 1'b1;
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                // RamWrite is decoded from the current state, so a write in
                // ACCESS during a reset cycle still reaches the RAM.
                RamWrite   = req_write;
                next_state = req_write ? DONE : WAIT;
            end
            WAIT: begin
                if (wait_cnt == 2'd0) begin
                    read_done  = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                // Requests are deliberately not looked at here: the finishing
                // port's Req is still high this cycle and must not re-grant.
                P0Ack      = (req_port == PORT_CORE);
                P1Ack      = (req_port == PORT_AUX);
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State register and WAIT counter
    // -----------------------------------------------------------------------
    always_ff @(posedge CoreClock) begin
        if (Reset) begin
            state    <= IDLE;
            wait_cnt <= 2'd0;
        end else begin
            state <= next_state;
            if (state == ACCESS) begin
                wait_cnt <= WAIT_LOAD;
            end else if (state == WAIT && wait_cnt != 2'd0) begin
                wait_cnt <= wait_cnt - 2'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Request registers: latched from the winner on the IDLE grant edge and
    // driven straight onto the RAM address/data pins.
    // -----------------------------------------------------------------------
    always_ff @(posedge CoreClock) begin
        if (Reset) begin
            req_port     <= PORT_CORE;
            req_write    <= 1'b0;
            RamAddress   <= '0;
            RamWriteData <= '0;
        end else if (grant_take) begin
            req_port     <= grant_port;
            req_write    <= sel_write;
            RamAddress   <= sel_address;
            RamWriteData <= sel_write_data;
        end
    end

    // -----------------------------------------------------------------------
    // Per-port read data. Only the port that owns the completing read is
    // updated; writes never touch these registers.
    // NOTE: these registers are reset because their zero value is visible to
    // the masters; a plain storage array would be left unreset.
    // -----------------------------------------------------------------------
    always_ff @(posedge CoreClock) begin
        if (Reset) begin
            P0ReadData <= '0;
            P1ReadData <= '0;
        end else if (read_done) begin
            if (req_port == PORT_CORE) begin
                P0ReadData <= RamReadData;
            end else begin
                P1ReadData <= RamReadData;
            end
        end
    end

endmodule : memory_bus_arbiter

// File: tb/tb_memory_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_memory_bus_arbiter
//
// Directed bench for memory_bus_arbiter. Two instances share clock and reset:
// u_dut uses RAM_READ_LATENCY = 1, u_dut_l2 uses RAM_READ_LATENCY = 2. Each
// has its own behavioural TempRam with the matching read latency.
// Tie-break expectations follow MEMORY_BUS_ARBITER_ROUND_ROBIN_EN.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_memory_bus_arbiter;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic              p0_req   [2];
    logic [ADDR_W-1:0] p0_addr  [2];
    logic [DATA_W-1:0] p0_wdata [2];
    logic              p0_write [2];
    logic              p0_ack   [2];
    logic [DATA_W-1:0] p0_rdata [2];

    logic              p1_req   [2];
    logic [ADDR_W-1:0] p1_addr  [2];
    logic [DATA_W-1:0] p1_wdata [2];
    logic              p1_write [2];
    logic              p1_ack   [2];
    logic [DATA_W-1:0] p1_rdata [2];

    logic [ADDR_W-1:0] ram_addr  [2];
    logic [DATA_W-1:0] ram_wdata [2];
    logic              ram_write [2];
    logic [DATA_W-1:0] ram_rdata [2];

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------------------------------------------------------- DUTs
    memory_bus_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_READ_LATENCY(1)
    ) u_dut (
        .CoreClock(clk), .Reset(rst),
        .P0Req(p0_req[0]), .P0Address(p0_addr[0]), .P0WriteData(p0_wdata[0]),
        .P0Write(p0_write[0]), .P0Ack(p0_ack[0]), .P0ReadData(p0_rdata[0]),
        .P1Req(p1_req[0]), .P1Address(p1_addr[0]), .P1WriteData(p1_wdata[0]),
        .P1Write(p1_write[0]), .P1Ack(p1_ack[0]), .P1ReadData(p1_rdata[0]),
        .RamAddress(ram_addr[0]), .RamWriteData(ram_wdata[0]),
        .RamWrite(ram_write[0]), .RamReadData(ram_rdata[0])
    );

    memory_bus_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_READ_LATENCY(2)
    ) u_dut_l2 (
        .CoreClock(clk), .Reset(rst),
        .P0Req(p0_req[1]), .P0Address(p0_addr[1]), .P0WriteData(p0_wdata[1]),
        .P0Write(p0_write[1]), .P0Ack(p0_ack[1]), .P0ReadData(p0_rdata[1]),
        .P1Req(p1_req[1]), .P1Address(p1_addr[1]), .P1WriteData(p1_wdata[1]),
        .P1Write(p1_write[1]), .P1Ack(p1_ack[1]), .P1ReadData(p1_rdata[1]),
        .RamAddress(ram_addr[1]), .RamWriteData(ram_wdata[1]),
        .RamWrite(ram_write[1]), .RamReadData(ram_rdata[1])
    );

    // ------------------------------------------------- TempRam models
    // q(t) = mem[address(t - latency)], read-before-write.
    logic [DATA_W-1:0] mem_a  [DEPTH];
    logic [DATA_W-1:0] pipe_a;
    logic [DATA_W-1:0] mem_b  [DEPTH];
    logic [DATA_W-1:0] pipe_b [2];

    always @(posedge clk) begin
        if (ram_write[0]) mem_a[ram_addr[0]] <= ram_wdata[0];
        pipe_a <= mem_a[ram_addr[0]];
    end
    assign ram_rdata[0] = pipe_a;

    always @(posedge clk) begin
        if (ram_write[1]) mem_b[ram_addr[1]] <= ram_wdata[1];
        pipe_b[0] <= mem_b[ram_addr[1]];
        pipe_b[1] <= pipe_b[0];
    end
    assign ram_rdata[1] = pipe_b[1];

    // ------------------------------------------------- stimulus helpers
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        for (int i = 0; i < 2; i++) begin
            p0_req[i] = 1'b0; p0_addr[i] = '0; p0_wdata[i] = '0; p0_write[i] = 1'b0;
            p1_req[i] = 1'b0; p1_addr[i] = '0; p1_wdata[i] = '0; p1_write[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) tick;
        rst = 1'b0;
    endtask

    task automatic set_req(input int inst, input int port, input logic wr,
                           input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        if (port == 0) begin
            p0_req[inst] = 1'b1; p0_write[inst] = wr; p0_addr[inst] = addr; p0_wdata[inst] = data;
        end else begin
            p1_req[inst] = 1'b1; p1_write[inst] = wr; p1_addr[inst] = addr; p1_wdata[inst] = data;
        end
    endtask

    // One access from IDLE; lat = cycles from request to Ack, -1 on timeout.
    // Returns with the DUT back in IDLE.
    task automatic access(input int inst, input int port, input logic wr,
                          input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                          output int lat);
        set_req(inst, port, wr, addr, data);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            tick;
            if ((port == 0 && p0_ack[inst]) || (port == 1 && p1_ack[inst])) begin
                lat = c;
                break;
            end
        end
        if (port == 0) p0_req[inst] = 1'b0;
        else           p1_req[inst] = 1'b0;
        tick;
    endtask

    // Both ports read on instance 0 in the same cycle; each drops Req on Ack.
    task automatic run_tie(output int a0, output int a1);
        set_req(0, 0, 1'b0, 14'h0010, '0);
        set_req(0, 1, 1'b0, 14'h0020, '0);
        a0 = -1;
        a1 = -1;
        for (int c = 1; c <= 12; c++) begin
            tick;
            if (p0_ack[0] && a0 < 0) begin a0 = c; p0_req[0] = 1'b0; end
            if (p1_ack[0] && a1 < 0) begin a1 = c; p1_req[0] = 1'b0; end
        end
        p0_req[0] = 1'b0;
        p1_req[0] = 1'b0;
    endtask

    // ------------------------------------------------- tests
    task automatic test_reset;
        do_reset;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (ram_write[i] !== 1'b0 || p0_ack[i] !== 1'b0 || p1_ack[i] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_ctrl[%0d]: RamWrite/P0Ack/P1Ack=%b%b%b want 000",
                         i, ram_write[i], p0_ack[i], p1_ack[i]);
            end
            n_cmp++;
            if (ram_addr[i] !== '0 || ram_wdata[i] !== '0) begin
                n_bad++;
                $display("FAIL reset_ram[%0d]: RamAddress=%h RamWriteData=%h want 0/0",
                         i, ram_addr[i], ram_wdata[i]);
            end
            n_cmp++;
            if (p0_rdata[i] !== '0 || p1_rdata[i] !== '0) begin
                n_bad++;
                $display("FAIL reset_rdata[%0d]: P0ReadData=%h P1ReadData=%h want 0/0",
                         i, p0_rdata[i], p1_rdata[i]);
            end
        end
    endtask

    task automatic test_write;
        set_req(0, 0, 1'b1, 14'h0010, 32'hDEADBEEF);
        n_cmp++;
        if (ram_write[0] !== 1'b0) begin
            n_bad++; $display("FAIL wr_c0_ramwrite: got %b want 0", ram_write[0]);
        end
        tick;
        n_cmp++;
        if (ram_write[0] !== 1'b1 || ram_addr[0] !== 14'h0010 || ram_wdata[0] !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL wr_c1_access: RamWrite=%b addr=%h data=%h want 1/0010/deadbeef",
                     ram_write[0], ram_addr[0], ram_wdata[0]);
        end
        n_cmp++;
        if (p0_ack[0] !== 1'b0) begin
            n_bad++; $display("FAIL wr_c1_ack: got %b want 0", p0_ack[0]);
        end
        tick;
        n_cmp++;
        if (p0_ack[0] !== 1'b1 || p1_ack[0] !== 1'b0 || ram_write[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_c2_ack: P0Ack=%b P1Ack=%b RamWrite=%b want 1/0/0",
                     p0_ack[0], p1_ack[0], ram_write[0]);
        end
        p0_req[0] = 1'b0;
        tick;
        n_cmp++;
        if (p0_ack[0] !== 1'b0) begin
            n_bad++; $display("FAIL wr_c3_ack_pulse: got %b want 0", p0_ack[0]);
        end
    endtask

    task automatic test_read;
        set_req(0, 0, 1'b0, 14'h0010, '0);
        tick;
        n_cmp++;
        if (ram_write[0] !== 1'b0 || ram_addr[0] !== 14'h0010) begin
            n_bad++;
            $display("FAIL rd_c1_access: RamWrite=%b addr=%h want 0/0010", ram_write[0], ram_addr[0]);
        end
        tick;
        n_cmp++;
        if (p0_ack[0] !== 1'b0) begin
            n_bad++; $display("FAIL rd_c2_ack: got %b want 0", p0_ack[0]);
        end
        tick;
        n_cmp++;
        if (p0_ack[0] !== 1'b1 || p0_rdata[0] !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL rd_c3_ack_data: P0Ack=%b P0ReadData=%h want 1/deadbeef",
                     p0_ack[0], p0_rdata[0]);
        end
        n_cmp++;
        if (p1_rdata[0] !== '0) begin
            n_bad++; $display("FAIL rd_p1_untouched: P1ReadData=%h want 0", p1_rdata[0]);
        end
        p0_req[0] = 1'b0;
        tick;
    endtask

    task automatic test_tie;
        int lat, a0, a1;
        access(0, 1, 1'b1, 14'h0020, 32'h12345678, lat);
        n_cmp++;
        if (lat !== 2) begin
            n_bad++; $display("FAIL tie_prep_p1_write: latency %0d want 2", lat);
        end
        do_reset;

        // From reset LastGrant = aux, so the core wins in both builds.
        run_tie(a0, a1);
        n_cmp++;
        if (a0 !== 3 || a1 !== 7) begin
            n_bad++; $display("FAIL tie1_order: P0Ack@%0d P1Ack@%0d want 3/7", a0, a1);
        end
        n_cmp++;
        if (p0_rdata[0] !== 32'hDEADBEEF || p1_rdata[0] !== 32'h12345678) begin
            n_bad++;
            $display("FAIL tie1_data: P0=%h P1=%h want deadbeef/12345678", p0_rdata[0], p1_rdata[0]);
        end

        // Solo core write: LastGrant becomes core; ReadData must not change.
        access(0, 0, 1'b1, 14'h0030, 32'hCAFEF00D, lat);
        n_cmp++;
        if (lat !== 2 || p0_rdata[0] !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL solo_write: latency %0d P0ReadData=%h want 2/deadbeef", lat, p0_rdata[0]);
        end

        run_tie(a0, a1);
`ifdef MEMORY_BUS_ARBITER_ROUND_ROBIN_EN
        n_cmp++;
        if (a1 !== 3 || a0 !== 7) begin
            n_bad++; $display("FAIL tie2_rr_order: P1Ack@%0d P0Ack@%0d want 3/7", a1, a0);
        end
`else
        n_cmp++;
        if (a0 !== 3 || a1 !== 7) begin
            n_bad++; $display("FAIL tie2_fixed_order: P0Ack@%0d P1Ack@%0d want 3/7", a0, a1);
        end
`endif
    endtask

    task automatic test_back_to_back;
        int p0_cnt, p0_before, last_c;
        bit p1_seen;
        p0_cnt = 0; p0_before = -1; last_c = -1; p1_seen = 1'b0;
        set_req(0, 0, 1'b0, 14'h0010, '0);
        set_req(0, 1, 1'b0, 14'h0020, '0);
        for (int c = 1; c <= 100; c++) begin
            tick;
            if (p0_ack[0]) begin
                p0_cnt++;
                last_c = c;
                if (p0_cnt == 8) p0_req[0] = 1'b0;
            end
            if (p1_ack[0]) begin
                p1_seen = 1'b1;
                p0_before = p0_cnt;
                last_c = c;
                p1_req[0] = 1'b0;
            end
            if (p0_cnt == 8 && p1_seen) break;
        end
        p0_req[0] = 1'b0;
        p1_req[0] = 1'b0;
        tick;
        n_cmp++;
        if (p0_cnt !== 8 || !p1_seen) begin
            n_bad++; $display("FAIL b2b_counts: P0 acks %0d P1 seen %0b want 8/1", p0_cnt, p1_seen);
        end
`ifdef MEMORY_BUS_ARBITER_ROUND_ROBIN_EN
        n_cmp++;
        if (p0_before < 0 || p0_before > 1) begin
            n_bad++; $display("FAIL b2b_rr_fair: P0 acks before P1Ack %0d want <=1", p0_before);
        end
`else
        n_cmp++;
        if (p0_before !== 8) begin
            n_bad++; $display("FAIL b2b_fixed_prio: P0 acks before P1Ack %0d want 8", p0_before);
        end
`endif
        // Nine reads at the minimum 4-cycle spacing end on cycle 35.
        n_cmp++;
        if (last_c !== 35) begin
            n_bad++; $display("FAIL b2b_spacing: last Ack @%0d want 35", last_c);
        end
        n_cmp++;
        if (p0_rdata[0] !== 32'hDEADBEEF || p1_rdata[0] !== 32'h12345678) begin
            n_bad++;
            $display("FAIL b2b_data: P0=%h P1=%h want deadbeef/12345678", p0_rdata[0], p1_rdata[0]);
        end
    endtask

    task automatic test_reset_in_wait;
        bit p1_ack_seen;
        do_reset;
        p1_ack_seen = 1'b0;
        set_req(0, 1, 1'b0, 14'h0020, '0);
        tick;                       // ACCESS
        tick;                       // WAIT
        rst = 1'b1;
        tick;                       // reset sampled at end of WAIT
        p1_ack_seen = p1_ack[0];
        n_cmp++;
        if (p1_ack[0] !== 1'b0 || p1_rdata[0] !== '0 || ram_write[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_wait_c3: P1Ack=%b P1ReadData=%h RamWrite=%b want 0/0/0",
                     p1_ack[0], p1_rdata[0], ram_write[0]);
        end
        rst = 1'b0;
        p1_req[0] = 1'b0;
        // A core write issued now is granted at once only if the state is IDLE.
        set_req(0, 0, 1'b1, 14'h0040, 32'h55AA55AA);
        tick;
        p1_ack_seen = p1_ack_seen | p1_ack[0];
        n_cmp++;
        if (ram_write[0] !== 1'b1 || ram_addr[0] !== 14'h0040) begin
            n_bad++;
            $display("FAIL rst_wait_idle: RamWrite=%b addr=%h want 1/0040", ram_write[0], ram_addr[0]);
        end
        tick;
        p1_ack_seen = p1_ack_seen | p1_ack[0];
        n_cmp++;
        if (p0_ack[0] !== 1'b1) begin
            n_bad++; $display("FAIL rst_wait_p0_ack: got %b want 1", p0_ack[0]);
        end
        p0_req[0] = 1'b0;
        tick;
        p1_ack_seen = p1_ack_seen | p1_ack[0];
        n_cmp++;
        if (p1_ack_seen !== 1'b0 || p1_rdata[0] !== '0) begin
            n_bad++;
            $display("FAIL rst_wait_no_p1: P1Ack seen=%b P1ReadData=%h want 0/0", p1_ack_seen, p1_rdata[0]);
        end
    endtask

    task automatic test_latency2;
        int lat;
        access(1, 0, 1'b1, 14'h0006, 32'h0BADF00D, lat);
        n_cmp++;
        if (lat !== 2) begin
            n_bad++; $display("FAIL l2_write0: latency %0d want 2", lat);
        end
        // Leaves RamAddress at 0x0005 so an early capture would see 0xAAAA5555.
        access(1, 1, 1'b1, 14'h0005, 32'hAAAA5555, lat);
        n_cmp++;
        if (lat !== 2) begin
            n_bad++; $display("FAIL l2_write1: latency %0d want 2", lat);
        end
        set_req(1, 0, 1'b0, 14'h0006, '0);
        tick;                       // 1: ACCESS
        tick;                       // 2: WAIT
        n_cmp++;
        if (p0_ack[1] !== 1'b0) begin
            n_bad++; $display("FAIL l2_c2_ack: got %b want 0", p0_ack[1]);
        end
        tick;                       // 3: WAIT
        n_cmp++;
        if (p0_ack[1] !== 1'b0 || p0_rdata[1] !== '0) begin
            n_bad++;
            $display("FAIL l2_c3: P0Ack=%b P0ReadData=%h want 0/0", p0_ack[1], p0_rdata[1]);
        end
        tick;                       // 4: DONE
        n_cmp++;
        if (p0_ack[1] !== 1'b1 || p0_rdata[1] !== 32'h0BADF00D) begin
            n_bad++;
            $display("FAIL l2_c4_ack_data: P0Ack=%b P0ReadData=%h want 1/0badf00d",
                     p0_ack[1], p0_rdata[1]);
        end
        n_cmp++;
        if (p1_rdata[1] !== '0) begin
            n_bad++; $display("FAIL l2_p1_untouched: P1ReadData=%h want 0", p1_rdata[1]);
        end
        p0_req[1] = 1'b0;
        tick;
    endtask

    // ------------------------------------------------- sequence
    initial begin
        test_reset;
        test_write;
        test_read;
        test_tie;
        test_back_to_back;
        test_reset_in_wait;
        test_latency2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule : tb_memory_bus_arbiter
